alu_exec_ctrl: RTL and testbench
================================

# alu_exec_ctrl

Sequencing stage that sits directly upstream of the 4-bit combinational ALU and also consumes its result. It accepts one command at a time over a valid/ready handshake and holds four 4-bit working registers. For each command it drives the ALU operand and control inputs, captures the ALU result, writes it back and presents it downstream with a zero flag. Immediate loads bypass the ALU.

## Interface
- No parameters: data width fixed at 4 bits, register count fixed at 4.
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_load  input  1  1 = load immediate into rd, 0 = ALU operation
- cmd_op  input  3  ALU control code: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 NOR, 110 NAND, 111 NOT A
- cmd_rd  input  2  destination register index
- cmd_rs1  input  2  source register for ALU A
- cmd_rs2  input  2  source register for ALU B
- cmd_imm  input  4  immediate value, used only when cmd_load = 1
- alu_a  output  4  to ALU operand A, registered
- alu_b  output  4  to ALU operand B, registered
- alu_ctrl  output  3  to ALU control, registered
- alu_result  input  4  from ALU, combinational function of alu_a/alu_b/alu_ctrl
- res_valid  output  1  result available
- res_ready  input  1  downstream accepts result
- res_data  output  4  result value (ALU result or immediate)
- res_rd  output  2  register index written
- res_zero  output  1  res_data == 0

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: cmd_ready = 1. On cmd_valid && cmd_ready:
  - cmd_load = 1: regs[rd] <= cmd_imm, res_data <= cmd_imm, res_rd <= rd, next state RESP.
  - cmd_load = 0: alu_a <= regs[rs1], alu_b <= regs[rs2], alu_ctrl <= cmd_op, latch rd, next state EXEC.
- EXEC (exactly 1 cycle): cmd_ready = 0. At the end of the cycle, regs[rd] <= alu_result, res_data <= alu_result, res_rd <= rd. Next state RESP.
- RESP: res_valid = 1, cmd_ready = 0. res_data, res_rd and res_zero stay stable until res_valid && res_ready, then next state IDLE.
- res_zero is derived from the registered res_data.
- Arithmetic is 4-bit modulo with no carry or borrow output. Example: 9 + 9 = 2, 5 − 9 = 12.
- rs1, rs2 and rd may alias. Operands are sampled at acceptance, before writeback, so rd == rs1 reads the old value.
- alu_a, alu_b and alu_ctrl hold their last values outside EXEC. They are not cleared after use.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - state = IDLE.
  - regs[0..3] = 0.
  - alu_a = alu_b = 0, alu_ctrl = 000.
  - res_data = 0, res_rd = 0, res_valid = 0, so res_zero = 1.
  - cmd_ready = 1 from the first cycle after reset releases.
- Reset in EXEC or RESP aborts the command: no writeback, no result handshake, all values return to reset values.
- ALU op latency: acceptance edge, then 1 EXEC cycle, then res_valid high. res_valid rises 2 cycles after acceptance.
- Load latency: res_valid rises 1 cycle after acceptance.
- Minimum command spacing with res_ready tied high: 3 cycles per ALU op, 2 cycles per load. cmd_ready returns in the cycle after the result handshake.
- Regfile writes happen only on the EXEC edge or the load-acceptance edge. A read and a write never occur in the same cycle.
- cmd_* inputs are ignored while cmd_ready = 0. res_ready is ignored while res_valid = 0.

## Test plan
- Reset release, then load r0 = 9 and r1 = 5 → two results: res_data 9/rd 0 and 5/rd 1, res_valid rising 1 cycle after each acceptance, res_zero = 0.
- ADD r2 = r0 + r1 (r0 = 9, r1 = 5) → alu_a = 9, alu_b = 5, alu_ctrl = 010 during EXEC; res_data = 14, res_rd = 2, valid 2 cycles after acceptance. SUB r3 = r1 − r0 → res_data = 12 (wrap).
- XOR r0 = r0 ^ r0 with r0 = 9 → res_data = 0, res_zero = 1, r0 = 0 afterwards. A follow-up OR r1 = r0 | r0 returns 0, confirming the write took effect.
- Hold res_ready low for 4 cycles during RESP → res_valid, res_data and res_rd stable, cmd_ready = 0, new cmd_valid pulses ignored. Result retires on the cycle res_ready rises, and cmd_ready = 1 on the next cycle.
- Sweep all 8 cmd_op codes with r0 = 4'b1010, r1 = 4'b0110 → results 0010, 1110, 0000, 0100, 1100, 0001, 1101, 0101.
- Assert rst_n low during EXEC of ADD r3 = r0 + r1 → r3 stays 0 after reset, res_valid never asserts for that command, all outputs at reset values.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: single-command sequencer in front of a 4-bit combinational ALU.
// It accepts one command over valid/ready and keeps four 4-bit working registers.
// For an ALU command it registers the operands and the ALU control, then writes the
// ALU result back. An immediate load bypasses the ALU. The result is held until the
// downstream handshake completes.
module alu_exec_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs1,
    input  logic [1:0] cmd_rs2,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_ctrl,
    input  logic [3:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic [1:0] res_rd,
    output logic       res_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] regs [4];
    logic [1:0] exec_rd_p0;
    logic       accept;

    assign accept   = cmd_valid && cmd_ready;
    assign res_zero = (res_data == 4'd0);

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_load ? RESP : EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Register file, ALU operand registers and result registers.
    // Operands are read at acceptance, before the writeback edge, so rd aliasing
    // rs1/rs2 sees the old value. ALU inputs are left holding after use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 4'd0;
            end
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_ctrl   <= 3'd0;
            exec_rd_p0 <= 2'd0;
            res_data   <= 4'd0;
            res_rd     <= 2'd0;
        end else if (accept) begin
            if (cmd_load) begin
                regs[cmd_rd] <= cmd_imm;
                res_data     <= cmd_imm;
                res_rd       <= cmd_rd;
            end else begin
                alu_a      <= regs[cmd_rs1];
                alu_b      <= regs[cmd_rs2];
                alu_ctrl   <= cmd_op;
                exec_rd_p0 <= cmd_rd;
            end
        end else if (state == EXEC) begin
            regs[exec_rd_p0] <= alu_result;
            res_data         <= alu_result;
            res_rd           <= exec_rd_p0;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a combinational ALU is attached to the ALU ports.
// Directed and random commands are compared against an array-based register model.
module tb_alu_exec_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [1:0] res_rd;
    logic       res_zero;

    int n_vec;
    int n_err;
    int mregs [4];
    int sweep_exp [8];

    alu_exec_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .res_zero   (res_zero)
    );

    always #5 clk = ~clk;

    // External combinational ALU.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b011:  alu_result = alu_a - alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = ~(alu_a | alu_b);
            3'b110:  alu_result = ~(alu_a & alu_b);
            default: alu_result = ~alu_a;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result with plain integer arithmetic on 0..15 values.
    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return (a + b) % 16;
            3:       return (a - b + 16) % 16;
            4:       return a ^ b;
            5:       return 15 - (a | b);
            6:       return 15 - (a & b);
            default: return 15 - a;
        endcase
    endfunction

    // Issue one command from IDLE (called at a falling edge), check latency and
    // result, optionally stall the result for 'hold' cycles, then retire it.
    task automatic run_cmd(input bit ld, input int op, input int rd, input int rs1,
                           input int rs2, input int imm, input int hold, output int got);
        int exp_v;
        int ea;
        int eb;
        ea    = mregs[rs1];
        eb    = mregs[rs2];
        exp_v = ld ? imm : ref_alu(op, ea, eb);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = 3'(op);
        cmd_rd    = 2'(rd);
        cmd_rs1   = 2'(rs1);
        cmd_rs2   = 2'(rs2);
        cmd_imm   = 4'(imm);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!ld) begin
            chk("exec_alu_a", alu_a, ea);
            chk("exec_alu_b", alu_b, eb);
            chk("exec_alu_ctrl", alu_ctrl, op);
            chk("exec_res_valid", res_valid, 0);
            chk("exec_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        mregs[rd] = exp_v;
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, exp_v);
        chk("res_rd", res_rd, rd);
        chk("res_zero", res_zero, (exp_v == 0) ? 1 : 0);
        chk("resp_cmd_ready", cmd_ready, 0);
        got = int'(res_data);
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_load  = 1'b1;
            cmd_rd    = 2'($urandom_range(0, 3));
            cmd_imm   = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_data", res_data, exp_v);
            chk("hold_res_rd", res_rd, rd);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("retire_res_valid", res_valid, 0);
        chk("retire_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int got;
        n_vec     = 0;
        n_err     = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'd0;
        cmd_rd    = 2'd0;
        cmd_rs1   = 2'd0;
        cmd_rs2   = 2'd0;
        cmd_imm   = 4'd0;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        sweep_exp = '{4'b0010, 4'b1110, 4'b0000, 4'b0100, 4'b1100, 4'b0001, 4'b1101, 4'b0101};

        repeat (2) @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_rd", res_rd, 0);
        chk("rst_res_zero", res_zero, 1);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Loads, ADD/SUB with wrap, self-XOR to zero and read-back.
        run_cmd(1, 0, 0, 0, 0, 9, 0, got);
        run_cmd(1, 0, 1, 0, 0, 5, 0, got);
        run_cmd(0, 2, 2, 0, 1, 0, 0, got);
        chk("add_14", got, 14);
        run_cmd(0, 3, 3, 1, 0, 0, 0, got);
        chk("sub_wrap_12", got, 12);
        run_cmd(0, 4, 0, 0, 0, 0, 0, got);
        chk("xor_self_0", got, 0);
        run_cmd(0, 1, 1, 0, 0, 0, 0, got);
        chk("or_after_xor_0", got, 0);

        // Back-pressure: result held 4 cycles while new commands are offered.
        run_cmd(1, 0, 2, 0, 0, 3, 4, got);
        run_cmd(0, 1, 3, 2, 2, 0, 0, got);
        chk("hold_ignored_cmds", got, 3);

        // All eight operations on 1010 / 0110.
        run_cmd(1, 0, 0, 0, 0, 10, 0, got);
        run_cmd(1, 0, 1, 0, 0, 6, 0, got);
        for (int op = 0; op < 8; op++) begin
            run_cmd(0, op, 2, 0, 1, 0, 0, got);
            chk($sformatf("sweep_op%0d", op), got, sweep_exp[op]);
        end

        // Random commands, including aliasing and stalls.
        for (int n = 0; n < 60; n++) begin
            run_cmd($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
                    $urandom_range(0, 2), got);
        end

        // Reset during EXEC aborts the ADD r3 = r0 + r1.
        run_cmd(1, 0, 0, 0, 0, 7, 0, got);
        run_cmd(1, 0, 1, 0, 0, 8, 0, got);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 3'b010;
        cmd_rd    = 2'd3;
        cmd_rs1   = 2'd0;
        cmd_rs2   = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_data", res_data, 0);
        chk("abort_res_rd", res_rd, 0);
        chk("abort_res_zero", res_zero, 1);
        chk("abort_alu_a", alu_a, 0);
        chk("abort_alu_b", alu_b, 0);
        chk("abort_alu_ctrl", alu_ctrl, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_valid", res_valid, 0);
        end
        run_cmd(0, 1, 2, 3, 3, 0, 0, got);
        chk("abort_r3_zero", got, 0);
        run_cmd(0, 2, 2, 0, 1, 0, 0, got);
        chk("abort_regs_cleared", got, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
